// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI byte-read/write memory responder.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ_DEF    = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEF   = 8'h02;
  localparam int         SYNC_STAGES_DEF = 2;
  localparam int         BIT_CNT_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_ADDR_LO = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_IGNORE  = 3'd6
  } state_t;

endpackage

// File: rtl/spi_mem_responder_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge
  import spi_mem_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The chain is deliberately not reset so that a line already low at reset
  // release produces no edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target: opcode, 16-bit address, then streaming read/write data
// bytes against a synchronous byte-wide memory port.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] CMD_READ    = CMD_READ_DEF,
  parameter logic [7:0] CMD_WRITE   = CMD_WRITE_DEF,
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  logic cs_n_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk (clk),
    .din (spi_cs_n),
    .dout(cs_n_s),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk (clk),
    .din (spi_sck),
    .dout(sck_s),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk (clk),
    .din (spi_mosi),
    .dout(mosi_s),
    .rise(mosi_rise),
    .fall(mosi_fall)
  );

  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

  state_t               state, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [14:0]          rx_sr;
  logic [7:0]           tx_sr;
  logic                 is_rd;
  logic                 rd_cap_p1;

  logic                 cs_end;
  logic                 last_bit;
  logic                 rx_shift;
  logic                 cmd_done;
  logic                 addr_load;
  logic                 rd_first;
  logic                 rd_next;
  logic                 wr_start;
  logic                 tx_drive;
  logic [7:0]           rx_byte;
  logic [15:0]          addr_full;

  assign rx_byte   = {rx_sr[6:0], mosi_s};
  assign addr_full = {rx_sr, mosi_s};
  assign last_bit  = (bit_cnt == '1);
  // A deselect always wins over any SCK edge seen in the same cycle.
  assign cs_end    = cs_rise | (cs_n_s & (state != ST_IDLE));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    rx_shift  = 1'b0;
    cmd_done  = 1'b0;
    addr_load = 1'b0;
    rd_first  = 1'b0;
    rd_next   = 1'b0;
    wr_start  = 1'b0;
    tx_drive  = 1'b0;
    if (cs_end) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_CMD;
        end
        ST_CMD: begin
          rx_shift = sck_rise;
          if (sck_rise && last_bit) begin
            cmd_done = 1'b1;
            if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) state_d = ST_ADDR_HI;
            else                                             state_d = ST_IGNORE;
          end
        end
        ST_ADDR_HI: begin
          rx_shift = sck_rise;
          if (sck_rise && last_bit) state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          rx_shift = sck_rise;
          if (sck_rise && last_bit) begin
            addr_load = 1'b1;
            rd_first  = is_rd;
            state_d   = is_rd ? ST_RD_DATA : ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          rx_shift = sck_rise;
          rd_next  = sck_rise & last_bit;
          tx_drive = sck_fall;
        end
        ST_WR_DATA: begin
          rx_shift = sck_rise;
          wr_start = sck_rise & last_bit;
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Shift registers: serial-in on SCK rise, serial-out on SCK fall
  always_ff @(posedge clk) begin
    if (rx_shift) rx_sr <= {rx_sr[13:0], mosi_s};
    if (rd_cap_p1 && state == ST_RD_DATA) tx_sr <= mem_rd_data;
    else if (tx_drive)                    tx_sr <= {tx_sr[6:0], 1'b0};
  end

  // Control, memory strobes and address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      is_rd       <= 1'b0;
      rd_cap_p1   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (cs_end || state == ST_IDLE) bit_cnt <= '0;
      else if (rx_shift)              bit_cnt <= bit_cnt + BIT_CNT_W'(1);

      if (cmd_done) is_rd <= (rx_byte == CMD_READ);

      mem_rd_en <= rd_first | rd_next;
      mem_wr_en <= wr_start;
      // Read data arrives one cycle after the strobe and is captured the cycle after that.
      rd_cap_p1 <= mem_rd_en;

      if (wr_start) mem_wr_data <= rx_byte;

      if (addr_load)                  mem_addr <= addr_full[ADDR_W-1:0];
      else if (rd_next || mem_wr_en)  mem_addr <= mem_addr + ADDR_W'(1);

      spi_miso_oe <= (state_d == ST_RD_DATA);
      if (state_d != ST_RD_DATA) spi_miso <= 1'b0;
      else if (tx_drive)         spi_miso <= tx_sr[7];

      busy <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench: bit-banged SPI master, behavioural memory and
// transaction-level expectations for reads, writes, aborts and resets.
module tb_spi_mem_responder;

  localparam int ADDR_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_cs_n;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  spi_mem_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  obs_oe_q[$];
  logic [7:0]  hdr_oe;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Synchronous memory: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_q.push_back({mem_addr, mem_wr_data});
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int nbits,
                          output logic [7:0] rx, output logic [7:0] oe_m);
    rx   = '0;
    oe_m = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i]   = spi_miso;
      oe_m[7-i] = spi_miso_oe;
      spi_sck   = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck   = 1'b0;
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    obs_q.delete();
    obs_oe_q.delete();
    hdr_oe = '0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (SYNC_STAGES + 6) @(negedge clk);
  endtask

  task automatic send_header(input logic [7:0] op, input logic [15:0] a);
    logic [7:0] rx, oe_m;
    spi_bits(op, 8, rx, oe_m);       hdr_oe |= oe_m;
    spi_bits(a[15:8], 8, rx, oe_m);  hdr_oe |= oe_m;
    spi_bits(a[7:0], 8, rx, oe_m);   hdr_oe |= oe_m;
  endtask

  task automatic clock_byte(input logic [7:0] wb, input int nbits);
    logic [7:0] rx, oe_m;
    spi_bits(wb, nbits, rx, oe_m);
    obs_q.push_back(rx);
    obs_oe_q.push_back(oe_m);
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++; if ({spi_miso, spi_miso_oe, busy, mem_rd_en, mem_wr_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {spi_miso, spi_miso_oe, busy, mem_rd_en, mem_wr_en}); end
    n_tests++; if (mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    n_tests++; if (mem_wr_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_wr_data: got %h expected 00", mem_wr_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_read_single();
    clear_logs();
    mem[16'h0042] = 8'hA5;
    mem[16'h0043] = 8'h3C;
    cs_low();
    n_tests++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL read_single_busy: got %b expected 1", busy); end
    send_header(8'h03, 16'h0042);
    clock_byte(8'h00, 8);
    cs_high();
    n_tests++; if (obs_q[0] !== 8'hA5) begin
      n_fail++; $display("FAIL read_single_data: got %h expected a5", obs_q[0]); end
    n_tests++; if (hdr_oe !== 8'h00 || obs_oe_q[0] !== 8'hFF) begin
      n_fail++; $display("FAIL read_single_oe: got hdr %h data %h expected 00 ff", hdr_oe, obs_oe_q[0]); end
    // First read at the target address plus one prefetch of the next address.
    n_tests++; if (rd_q.size() != 2 || rd_q[0] !== 16'h0042 || rd_q[1] !== 16'h0043) begin
      n_fail++; $display("FAIL read_single_strobes: got %0d reads first %h expected 2 reads 0042,0043",
                         rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx); end
    n_tests++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL read_single_end: got oe %b miso %b busy %b expected 0 0 0", spi_miso_oe, spi_miso, busy); end
  endtask

  task automatic test_read_wrap();
    clear_logs();
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    cs_low();
    send_header(8'h03, 16'hFFFF);
    clock_byte(8'h00, 8);
    clock_byte(8'h00, 8);
    cs_high();
    n_tests++; if (obs_q[0] !== 8'h11 || obs_q[1] !== 8'h22) begin
      n_fail++; $display("FAIL read_wrap_data: got %h %h expected 11 22", obs_q[0], obs_q[1]); end
    n_tests++; if (rd_q.size() != 3 || rd_q[0] !== 16'hFFFF || rd_q[1] !== 16'h0000 || rd_q[2] !== 16'h0001) begin
      n_fail++; $display("FAIL read_wrap_strobes: got %0d reads expected ffff,0000,0001", rd_q.size()); end
  endtask

  task automatic test_read_random();
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      logic [7:0]  exp_b[4];
      int          n;
      int          bad_data, bad_rd;
      clear_logs();
      a = 16'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        exp_b[i] = 8'($urandom);
        mem[16'(a + 16'(i))] = exp_b[i];
      end
      cs_low();
      send_header(8'h03, a);
      for (int i = 0; i < n; i++) clock_byte(8'($urandom), 8);
      cs_high();
      bad_data = 0;
      for (int i = 0; i < n; i++) if (obs_q[i] !== exp_b[i] || obs_oe_q[i] !== 8'hFF) bad_data++;
      n_tests++; if (bad_data != 0) begin
        n_fail++; $display("FAIL read_random_data: addr %h len %0d got %0d bad bytes expected 0", a, n, bad_data); end
      bad_rd = (rd_q.size() != n + 1) ? 1 : 0;
      for (int i = 0; i < rd_q.size() && i <= n; i++) if (rd_q[i] !== 16'(a + 16'(i))) bad_rd++;
      n_tests++; if (bad_rd != 0) begin
        n_fail++; $display("FAIL read_random_strobes: addr %h len %0d got %0d reads expected %0d sequential", a, n, rd_q.size(), n + 1); end
    end
  endtask

  task automatic test_write_burst();
    logic [15:0] a;
    logic [7:0]  wb[4];
    int          n, bad;
    clear_logs();
    cs_low();
    send_header(8'h02, 16'h0010);
    clock_byte(8'hAB, 8);
    clock_byte(8'hCD, 8);
    cs_high();
    n_tests++; if (wr_q.size() != 2 || wr_q[0] !== 24'h0010AB || wr_q[1] !== 24'h0011CD) begin
      n_fail++; $display("FAIL write_fixed: got %0d writes first %h expected 0010ab,0011cd",
                         wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 24'hxxxxxx); end
    n_tests++; if (rd_q.size() != 0 || hdr_oe !== 8'h00 || obs_oe_q[0] !== 8'h00) begin
      n_fail++; $display("FAIL write_no_read: got %0d reads oe %h expected 0 reads oe 00", rd_q.size(), hdr_oe | obs_oe_q[0]); end
    clear_logs();
    a = 16'($urandom);
    n = $urandom_range(1, 4);
    cs_low();
    send_header(8'h02, a);
    for (int i = 0; i < n; i++) begin
      wb[i] = 8'($urandom);
      clock_byte(wb[i], 8);
    end
    cs_high();
    bad = (wr_q.size() != n) ? 1 : 0;
    for (int i = 0; i < wr_q.size() && i < n; i++)
      if (wr_q[i] !== {16'(a + 16'(i)), wb[i]}) bad++;
    n_tests++; if (bad != 0) begin
      n_fail++; $display("FAIL write_random: addr %h len %0d got %0d writes expected %0d matching", a, n, wr_q.size(), n); end
  endtask

  task automatic test_unknown_opcode();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] op;
      if (k == 0) op = 8'h9F;
      else do op = 8'($urandom); while (op == 8'h02 || op == 8'h03);
      clear_logs();
      cs_low();
      send_header(op, 16'h0000);
      clock_byte(8'hAA, 8);
      n_tests++; if (busy !== 1'b1) begin
        n_fail++; $display("FAIL ignore_busy: op %h got %b expected 1", op, busy); end
      cs_high();
      n_tests++; if (rd_q.size() != 0 || wr_q.size() != 0) begin
        n_fail++; $display("FAIL ignore_strobes: op %h got %0d rd %0d wr expected 0 0", op, rd_q.size(), wr_q.size()); end
      n_tests++; if (hdr_oe !== 8'h00 || obs_oe_q[0] !== 8'h00 || obs_q[0] !== 8'h00) begin
        n_fail++; $display("FAIL ignore_oe: op %h got oe %h miso %h expected 00 00", op, hdr_oe | obs_oe_q[0], obs_q[0]); end
      n_tests++; if (busy !== 1'b0) begin
        n_fail++; $display("FAIL ignore_busy_end: op %h got %b expected 0", op, busy); end
    end
  endtask

  task automatic test_abort();
    clear_logs();
    cs_low();
    send_header(8'h02, 16'h0020);
    clock_byte(8'($urandom), 5);
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy %b oe %b expected 0 0", busy, spi_miso_oe); end
    repeat (6) @(negedge clk);
    n_tests++; if (wr_q.size() != 0) begin
      n_fail++; $display("FAIL abort_no_write: got %0d writes expected 0", wr_q.size()); end
    clear_logs();
    cs_low();
    spi_bits(8'h03, 8, obs_oe_q[0], hdr_oe);
    spi_bits(8'h00, 8, obs_oe_q[0], hdr_oe);
    spi_bits(8'h20, 4, obs_oe_q[0], hdr_oe);
    cs_high();
    n_tests++; if (rd_q.size() != 0) begin
      n_fail++; $display("FAIL abort_no_read: got %0d reads expected 0", rd_q.size()); end
    clear_logs();
    mem[16'h0020] = 8'h5E;
    cs_low();
    send_header(8'h03, 16'h0020);
    clock_byte(8'h00, 8);
    cs_high();
    n_tests++; if (obs_q[0] !== 8'h5E || rd_q.size() == 0 || rd_q[0] !== 16'h0020) begin
      n_fail++; $display("FAIL abort_followup_read: got %h with %0d reads expected 5e at 0020", obs_q[0], rd_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] a;
    logic [7:0]  d;
    a = 16'($urandom);
    d = 8'($urandom);
    mem[a] = d;
    clear_logs();
    cs_low();
    send_header(8'h03, a);
    clock_byte(8'h00, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if ({spi_miso, spi_miso_oe, busy, mem_rd_en, mem_wr_en} !== 5'b0 || mem_addr !== '0 || mem_wr_data !== '0) begin
      n_fail++; $display("FAIL reset_mid_read: got ctrl %b addr %h wd %h expected 0 0 0",
                         {spi_miso, spi_miso_oe, busy, mem_rd_en, mem_wr_en}, mem_addr, mem_wr_data); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    send_header(8'h03, a);
    clock_byte(8'h00, 8);
    n_tests++; if (busy !== 1'b0 || rd_q.size() != 0 || hdr_oe !== 8'h00 || obs_oe_q[0] !== 8'h00) begin
      n_fail++; $display("FAIL reset_held_cs_ignored: got busy %b reads %0d oe %h expected 0 0 00",
                         busy, rd_q.size(), hdr_oe | obs_oe_q[0]); end
    cs_high();
    clear_logs();
    cs_low();
    send_header(8'h03, a);
    clock_byte(8'h00, 8);
    cs_high();
    n_tests++; if (obs_q[0] !== d) begin
      n_fail++; $display("FAIL reset_then_read: got %h expected %h", obs_q[0], d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0]  wb[3];
    int          bad;
    a = 16'($urandom);
    clear_logs();
    cs_low();
    send_header(8'h02, a);
    for (int i = 0; i < 3; i++) begin
      wb[i] = 8'($urandom);
      clock_byte(wb[i], 8);
    end
    cs_high();
    clear_logs();
    cs_low();
    send_header(8'h03, a);
    for (int i = 0; i < 3; i++) clock_byte(8'h00, 8);
    cs_high();
    bad = 0;
    for (int i = 0; i < 3; i++) if (obs_q[i] !== wb[i]) bad++;
    n_tests++; if (bad != 0) begin
      n_fail++; $display("FAIL back_to_back_readback: addr %h got %h %h %h expected %h %h %h",
                         a, obs_q[0], obs_q[1], obs_q[2], wb[0], wb[1], wb[2]); end
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_read_wrap();
    test_read_random();
    test_write_burst();
    test_unknown_opcode();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
